iq_unpacker: RTL and testbench

IQ_UNPACKER -- requirements
Module: iq_unpacker

---
 rtl/iq_pkg.sv | 17 +
 rtl/iq_fifo.sv | 48 ++++
 rtl/iq_unpacker.sv | 131 +++++++++++++
 tb/tb_iq_unpacker.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/iq_pkg.sv
// Shared types and default parameters for the IQ unpacker.
// FSM encoding lives here so the bench and RTL agree on it.
package iq_pkg;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HOLD  = 1'b1
   } iq_state_t;

   localparam int DEF_DATA_WIDTH   = 32;
   localparam int DEF_SAMPLE_WIDTH = 16;
   localparam int DEF_OUT_WIDTH    = 32;
   localparam int DEF_QUANT_BITS   = 10;
   localparam int DEF_FIFO_DEPTH   = 16;
   localparam int DEF_BYTE_SWAP    = 0;

endpackage

// File: rtl/iq_fifo.sv
// Word FIFO with registered pointers and show-ahead read data.
// Pointers carry one extra wrap bit to tell full from empty.
module iq_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             wr_ok;
   logic             rd_ok;

   assign wr_ok = wr_en & ~full;
   assign rd_ok = rd_en & ~empty;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   assign rd_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/iq_unpacker.sv
// Unpacks buffered I/Q words into quantised sample pairs,
// one pair per handshake, pair 0 (low bits) first.
module iq_unpacker
   import iq_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
   parameter int OUT_WIDTH    = DEF_OUT_WIDTH,
   parameter int QUANT_BITS   = DEF_QUANT_BITS,
   parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
   parameter int BYTE_SWAP    = DEF_BYTE_SWAP
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  wr_en,
   output logic                  full,
   output logic [OUT_WIDTH-1:0]  i_out,
   output logic [OUT_WIDTH-1:0]  q_out,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  overflow,
   output logic [31:0]           pair_count
);

   localparam int PW    = 2 * SAMPLE_WIDTH;
   localparam int PAIRS = DATA_WIDTH / PW;
   localparam int KW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
   localparam int NB    = SAMPLE_WIDTH / 8;
   localparam logic [KW-1:0] K_LAST = KW'(PAIRS - 1);

   iq_state_t             state;
   iq_state_t             state_nxt;
   logic [KW-1:0]         k;
   logic [KW-1:0]         k_nxt;
   logic [DATA_WIDTH-1:0] hold;
   logic [DATA_WIDTH-1:0] fifo_data;
   logic                  fifo_empty;
   logic                  pop;
   logic                  hs;
   logic [PW-1:0]         pair;

   iq_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_data (data_in),
      .rd_en   (pop),
      .rd_data (fifo_data),
      .full    (full),
      .empty   (fifo_empty)
   );

   assign out_valid = (state == ST_HOLD);
   assign hs        = out_valid & out_ready;

   always_comb begin
      state_nxt = state;
      k_nxt     = k;
      pop       = 1'b0;
      unique case (state)
         ST_EMPTY: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               k_nxt     = '0;
               state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               if (k != K_LAST) begin
                  k_nxt = k + 1'b1;
               end else begin
                  k_nxt = '0;
                  if (!fifo_empty) pop = 1'b1;
                  else state_nxt = ST_EMPTY;
               end
            end
         end
         default: state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= ST_EMPTY;
         k          <= '0;
         hold       <= '0;
         overflow   <= 1'b0;
         pair_count <= '0;
      end else begin
         state <= state_nxt;
         k     <= k_nxt;
         if (pop)          hold       <= fifo_data;
         if (wr_en & full) overflow   <= 1'b1;
         if (hs)           pair_count <= pair_count + 1'b1;
      end
   end

   // Byte reordering is confined to a single sample.
   function automatic logic [SAMPLE_WIDTH-1:0] order(
      input logic [SAMPLE_WIDTH-1:0] s
   );
      logic [SAMPLE_WIDTH-1:0] r;
      r = s;
      if (BYTE_SWAP != 0) begin
         for (int b = 0; b < NB; b++) begin
            r[b*8 +: 8] = s[(NB-1-b)*8 +: 8];
         end
      end
      return r;
   endfunction

   function automatic logic [OUT_WIDTH-1:0] quant(
      input logic [SAMPLE_WIDTH-1:0] s
   );
      logic signed [OUT_WIDTH-1:0] e;
      e = OUT_WIDTH'($signed(s));
      return e << QUANT_BITS;
   endfunction

   always_comb begin
      pair  = hold[32'(k) * PW +: PW];
      i_out = quant(order(pair[SAMPLE_WIDTH-1:0]));
      q_out = quant(order(pair[PW-1:SAMPLE_WIDTH]));
   end

endmodule

// File: tb/tb_iq_unpacker.sv
// Directed checks of iq_unpacker in three configurations:
// defaults, byte-swapped samples and 64-bit words.
module tb_iq_unpacker;

   logic        clock = 1'b0;
   logic        reset;

   logic [31:0] d_a, d_b;
   logic [63:0] d_c;
   logic        wr_a, wr_b, wr_c;
   logic        rdy_a, rdy_b, rdy_c;
   logic        full_a, full_b, full_c;
   logic        v_a, v_b, v_c;
   logic        ovf_a, ovf_b, ovf_c;
   logic [31:0] i_a, q_a, i_b, q_b, i_c, q_c;
   logic [31:0] pc_a, pc_b, pc_c;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] pw;
   logic [31:0] ew;

   always #5 clock = ~clock;

   iq_unpacker u_a (
      .clock(clock), .reset(reset), .data_in(d_a), .wr_en(wr_a),
      .full(full_a), .i_out(i_a), .q_out(q_a), .out_valid(v_a),
      .out_ready(rdy_a), .overflow(ovf_a), .pair_count(pc_a)
   );

   iq_unpacker #(.BYTE_SWAP(1)) u_b (
      .clock(clock), .reset(reset), .data_in(d_b), .wr_en(wr_b),
      .full(full_b), .i_out(i_b), .q_out(q_b), .out_valid(v_b),
      .out_ready(rdy_b), .overflow(ovf_b), .pair_count(pc_b)
   );

   iq_unpacker #(.DATA_WIDTH(64)) u_c (
      .clock(clock), .reset(reset), .data_in(d_c), .wr_en(wr_c),
      .full(full_c), .i_out(i_c), .q_out(q_c), .out_valid(v_c),
      .out_ready(rdy_c), .overflow(ovf_c), .pair_count(pc_c)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Sign-extend a 16-bit sample and scale by 2^10.
   function automatic logic [31:0] qz(input logic [15:0] s);
      return {{6{s[15]}}, s, 10'b0};
   endfunction

   function automatic logic [31:0] wv(input int n);
      logic [15:0] lo;
      lo = 16'(n * 291 + 5);
      return {~lo, lo};
   endfunction

   initial begin
      reset = 1'b0;
      d_a = '0; d_b = '0; d_c = '0;
      wr_a = 0; wr_b = 0; wr_c = 0;
      rdy_a = 0; rdy_b = 0; rdy_c = 0;
      repeat (2) tick();
      chk("rst_valid", v_a, 0);
      chk("rst_i", i_a, 0);
      chk("rst_q", q_a, 0);
      chk("rst_full", full_a, 0);
      chk("rst_ovf", ovf_a, 0);
      chk("rst_pc", pc_a, 0);
      chk("rst_valid_c", v_c, 0);

      reset = 1'b1;
      tick();
      wr_a = 1; d_a = 32'h12345678;
      wr_b = 1; d_b = 32'h12345678;
      wr_c = 1; d_c = 64'h1122334455667788;
      tick();
      wr_a = 0; wr_b = 0; wr_c = 0;
      chk("lat_t1_valid", v_a, 0);
      tick();
      chk("lat_t2_valid", v_a, 1);
      chk("dflt_i", i_a, 32'h0159E000);
      chk("dflt_q", q_a, 32'h0048D000);
      chk("swap_i", i_b, 32'h01E15800);
      chk("swap_q", q_b, 32'h00D04800);
      chk("w64_valid", v_c, 1);
      chk("w64_p0_i", i_c, 32'h01DE2000);
      chk("w64_p0_q", q_c, 32'h01559800);

      tick();
      chk("stall_valid", v_a, 1);
      chk("stall_i", i_a, 32'h0159E000);
      chk("stall_q", q_a, 32'h0048D000);

      rdy_a = 1; rdy_c = 1;
      tick();
      chk("hs_pc", pc_a, 1);
      chk("hs_valid", v_a, 0);
      chk("w64_p1_valid", v_c, 1);
      chk("w64_p1_i", i_c, 32'h00CD1000);
      chk("w64_p1_q", q_c, 32'h00448800);
      chk("w64_pc1", pc_c, 1);
      tick();
      chk("w64_done_valid", v_c, 0);
      chk("w64_pc2", pc_c, 2);
      rdy_a = 0; rdy_c = 0;

      wr_a = 1; d_a = 32'h87214365;
      tick();
      wr_a = 0;
      tick();
      chk("neg_i", i_a, 32'h010D9400);
      chk("neg_q", q_a, 32'hFE1C8400);
      rdy_a = 1;
      tick();
      rdy_a = 0;
      chk("neg_pc", pc_a, 2);

      // One word parks in the holding register, 16 fill the FIFO.
      pw = 32'h0BAD0ACE;
      wr_a = 1; d_a = pw;
      tick();
      for (int n = 0; n < 17; n++) begin
         d_a = wv(n); wr_a = 1;
         tick();
         if (n == 14) chk("full_at_15", full_a, 0);
         if (n == 15) begin
            chk("full_at_16", full_a, 1);
            chk("ovf_at_16", ovf_a, 0);
         end
         if (n == 16) begin
            chk("full_at_17", full_a, 1);
            chk("ovf_at_17", ovf_a, 1);
         end
      end
      wr_a = 0;

      rdy_a = 1;
      for (int j = 0; j < 17; j++) begin
         ew = (j == 0) ? pw : wv(j - 1);
         chk($sformatf("drain%0d_valid", j), v_a, 1);
         chk($sformatf("drain%0d_i", j), i_a, qz(ew[15:0]));
         chk($sformatf("drain%0d_q", j), q_a, qz(ew[31:16]));
         tick();
      end
      rdy_a = 0;
      chk("drain_end_valid", v_a, 0);
      chk("drain_end_full", full_a, 0);
      chk("drain_pc", pc_a, 19);
      chk("ovf_sticky", ovf_a, 1);

      wr_c = 1; d_c = 64'hDEADBEEF_CAFEF00D;
      tick();
      wr_c = 0;
      tick();
      tick();
      chk("mid_p0_valid", v_c, 1);
      rdy_c = 1;
      tick();
      rdy_c = 0;
      chk("mid_p1_i", i_c, qz(16'hBEEF));

      reset = 1'b0;
      #1;
      chk("arst_valid", v_c, 0);
      chk("arst_i", i_c, 0);
      chk("arst_q", q_c, 0);
      chk("arst_pc", pc_c, 0);
      chk("arst_full", full_c, 0);
      chk("arst_ovf_a", ovf_a, 0);
      chk("arst_pc_a", pc_a, 0);
      chk("arst_valid_b", v_b, 0);
      tick();
      reset = 1'b1;
      tick();

      wr_c = 1; d_c = 64'h7FFF000300020001;
      tick();
      wr_c = 0;
      chk("post_t1_valid", v_c, 0);
      tick();
      chk("post_valid", v_c, 1);
      chk("post_p0_i", i_c, 32'h00000400);
      chk("post_p0_q", q_c, 32'h00000800);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
